// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It walks a sequential PC, issues single-word
//   reads to instruction memory over a level req/ack handshake (at most one
//   outstanding), and buffers the returned words in a small first-word
//   fall-through prefetch FIFO that feeds the datapath over valid/ready.
//   A redirect pulse flushes the FIFO, discards any in-flight word, and
//   restarts fetching at the new PC.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     read request to instruction memory (level)
//   imem_addr    byte address of the request, [1:0] always zero
//   imem_ack     completes the request when high together with imem_req
//   imem_rdata   instruction word, valid in the ack cycle
//   redirect     one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  new fetch address, [1:0] ignored
//   instr_valid  FIFO head holds an instruction
//   instr        instruction at the FIFO head (zero when empty)
//   instr_pc     address of instr (zero when empty)
//   instr_ready  datapath consumes the head on instr_valid & instr_ready
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int            DATA_W  = 32;
  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       fetch_pc;
  logic [31:0]       pend_pc;
  logic [31:0]       redir_pc_al;
  logic              ack_hit;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count, count_nxt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [31:0]       mem_pc    [DEPTH];

  assign redir_pc_al = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req    = (state != IDLE);
  assign imem_addr   = fetch_pc;
  assign ack_hit     = imem_req & imem_ack;

  // Only a normal request delivers data; acks in DROP, or coinciding with a
  // redirect, belong to a stale stream and are discarded.
  assign push = (state == REQ) & imem_ack & ~redirect;
  assign pop  = instr_valid & instr_ready & ~redirect;

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
    if (redirect) count_nxt = '0;
  end

  // Next-state logic. An outstanding request occupies one FIFO slot, so a
  // new request is launched only when the post-edge count leaves room for it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (redirect || (count_nxt < DEPTH_C)) state_nxt = REQ;
      end
      REQ: begin
        if (redirect)     state_nxt = imem_ack ? REQ : DROP;
        else if (imem_ack) state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
      end
      DROP: begin
        if (imem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // fetch_pc doubles as the request address, so while a stale request is
  // still waiting for its ack the redirect target is parked in pend_pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      if ((state == IDLE) || ack_hit) fetch_pc <= redir_pc_al;
    end else if (ack_hit) begin
      fetch_pc <= (state == DROP) ? pend_pc : fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (redirect && imem_req && !imem_ack) pend_pc <= redir_pc_al;
  end

  // ---- FIFO control stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // ---- FIFO storage stage ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // Storage is not reset; gating with valid gives zero outputs when empty.
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Reference model: after reset or a redirect the datapath must see the
  // word stream pc, pc+4, pc+8, ... (mod 2^32) in order, nothing else.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    refill();
  endfunction

  // Memory responder: random or fixed wait states per request.
  int lat_min = 0, lat_max = 0, cur_lat = 0, wait_cnt = 0, ack_cnt = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && imem_req) begin
        check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prev_pend) check("addr_hold", imem_addr, prev_addr);
      end
      if (imem_req) begin
        if (wait_cnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          ack_cnt++;
          wait_cnt   = 0;
          cur_lat    = $urandom_range(lat_max, lat_min);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
        cur_lat  = $urandom_range(lat_max, lat_min);
      end
      prev_pend = imem_req & ~imem_ack;
      prev_addr = imem_addr;
    end
  end

  // Monitor: pops the scoreboard on every accepted instruction.
  int          pop_cnt  = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_instr = '0, hold_pc = '0;

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst_n && hold_prev) begin
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, hold_instr);
      check("hold_pc", instr_pc, hold_pc);
    end
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      e = exp_q.pop_front();
      refill();
      check("instr_pc", instr_pc, e);
      check("instr_data", instr, mem_word(e));
      pop_cnt++;
    end
    hold_prev  = rst_n & instr_valid & ~instr_ready & ~redirect;
    hold_instr = instr;
    hold_pc    = instr_pc;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lmin, input int lmax, input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    instr_ready = rdy;
    lat_min     = lmin;
    lat_max     = lmax;
    repeat (3) @(posedge clk);
    @(negedge clk);
    restart(RESET_PC);
    ack_cnt = 0;
    rst_n   = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    restart(pc & 32'hFFFF_FFFC);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    logic found;
    found = instr_valid;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    check({name, "_timeout"}, {31'd0, found}, 32'd1);
    if (found) check({name, "_pc"}, instr_pc, exp_pc);
  endtask

  initial begin
    logic found;
    int   p0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);

    // Zero-wait memory, ready high: first word right after its ack, then
    // one instruction per cycle.
    do_reset(0, 0, 1'b1);
    tick();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    tick();
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("first_pc", instr_pc, RESET_PC);
    p0 = pop_cnt;
    repeat (20) tick();
    check("throughput", pop_cnt - p0, 32'd20);

    // Ready low: exactly DEPTH acks, then the request drops.
    do_reset(0, 0, 1'b0);
    repeat (10) tick();
    check("full_acks", ack_cnt, 32'd4);
    check("full_req", {31'd0, imem_req}, 32'd0);
    check("full_head", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h10);
    repeat (12) tick();

    // Redirect while a slow request for 0x8 is pending.
    do_reset(3, 3, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = imem_req & (imem_addr == 32'h8);
    end
    check("pend8_timeout", {31'd0, found}, 32'd1);
    pulse_redirect(32'h0000_0103);
    tick();
    redirect = 1'b0;
    check("drop_valid", {31'd0, instr_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      found = imem_req & imem_ack;
      tick();
    end
    check("drop_ack_timeout", {31'd0, found}, 32'd1);
    check("drop_next_addr", imem_addr, 32'h100);
    wait_valid("drop_first", 32'h100);
    repeat (20) tick();

    // Redirect coinciding with an ack and a pop while all slots are used.
    do_reset(0, 0, 1'b0);
    repeat (8) tick();
    instr_ready = 1'b1;
    tick();
    pulse_redirect(32'h0000_4446);
    tick();
    redirect = 1'b0;
    check("coinc_valid", {31'd0, instr_valid}, 32'd0);
    check("coinc_addr", imem_addr, 32'h4444);
    wait_valid("coinc_first", 32'h4444);
    repeat (10) tick();

    // Redirect from IDLE: new address on the very next cycle.
    do_reset(0, 0, 1'b0);
    repeat (8) tick();
    pulse_redirect(32'h2000_0041);
    tick();
    redirect = 1'b0;
    check("idle_redir_req", {31'd0, imem_req}, 32'd1);
    check("idle_redir_addr", imem_addr, 32'h2000_0040);
    check("idle_redir_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    wait_valid("idle_redir_first", 32'h2000_0040);
    repeat (8) tick();

    // Address wrap at the top of the address space.
    do_reset(0, 0, 1'b1);
    repeat (3) tick();
    pulse_redirect(32'hFFFF_FFF8);
    tick();
    redirect = 1'b0;
    wait_valid("wrap_first", 32'hFFFF_FFF8);
    p0 = pop_cnt;
    repeat (6) tick();
    check("wrap_progress", {31'd0, (pop_cnt - p0) >= 3}, 32'd1);

    // Asynchronous reset in the middle of a request.
    do_reset(3, 3, 1'b1);
    repeat (9) tick();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      found = imem_req;
      if (!found) tick();
    end
    check("areset_pre_req", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_req", {31'd0, imem_req}, 32'd0);
    check("areset_valid", {31'd0, instr_valid}, 32'd0);
    check("areset_addr", imem_addr, RESET_PC);
    do_reset(0, 2, 1'b1);
    tick();
    check("areset_restart_addr", imem_addr, RESET_PC);
    wait_valid("areset_first", RESET_PC);
    repeat (10) tick();

    // Random traffic: wait states, back-pressure and redirects.
    do_reset(0, 3, 1'b1);
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = (($urandom % 4) != 0) || (i % 200 < 150 && i % 200 > 140);
      if (i % 200 >= 100 && i % 200 < 115) instr_ready = 1'b0;
      if (($urandom % 40) == 0) begin
        pulse_redirect($urandom);
      end else begin
        redirect    = 1'b0;
        redirect_pc = $urandom;
      end
      tick();
    end
    redirect = 1'b0;
    check("random_progress", {31'd0, (pop_cnt - p0) > 500}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
